usrt_receiver: RTL and testbench
================================

// Module: usrt_receiver
// PURPOSE
//  Receive end of the USRT link: deserialises frames driven on rxd/rts_in by the
//  ssa3 transmitter. Bits are timed by the external usrt_clk and sampled in the
//  clk domain. Delivers 7- or 8-bit characters on a valid/ack handshake, with
//  framing and overrun flags. Sits beside the transmitter top, fed from the
//  board pins.
// PARAMETERS
//  SYNC_STAGES  2  flip-flop depth of the input synchronisers (usrt_clk, rts_in, rxd); min 2
// PORTS
//  clk        in   1  FPGA system clock; every register is clocked on its posedge
//  rst_n      in   1  asynchronous, active-low reset
//  usrt_clk   in   1  external bit clock (asynchronous to clk)
//  rts_in     in   1  transmitter "sending" indication; high for the whole frame
//  rxd        in   1  serial data, LSB first
//  size8      in   1  1: 8 data bits, 0: 7 data bits; sampled at start-bit detection
//  rx_ack     in   1  consumer takes rx_data; only meaningful while rx_valid=1
//  rx_data    out  8  received character; bit7 forced to 0 in 7-bit mode
//  rx_valid   out  1  rx_data holds an unconsumed character
//  frame_err  out  1  one-clk pulse: stop bit sampled as 0
//  overrun    out  1  sticky: a character was lost because rx_valid was still set
//  busy       out  1  FSM is not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0,
//   all synchroniser stages=0. Reset may assert mid-frame; the frame is dropped silently.
//  Sampling: usrt_clk, rts_in and rxd each pass through SYNC_STAGES flops. A
//   registered falling-edge detect on the synchronised usrt_clk yields the strobe
//   smp (one clk wide). smp falls mid-bit, because the transmitter updates on rising
//   edges. rxd and rts_in are read only when smp=1.
//  Frame: start bit (0), then N data bits LSB first (N=8 if size8 else 7), then one
//   stop bit (1). Idle line is 1.
//  FSM (advances only on smp=1, except as noted under Abort):
//   IDLE  -> DATA  when rts=1 and rxd=0. Latch size8 into sz, clear bit_cnt, clear shift.
//   DATA  -> shift rxd in at bit position bit_cnt; bit_cnt+1. After bit N-1 -> STOP.
//   STOP  -> IDLE; rxd=1 delivers the character; rxd=0 pulses frame_err, nothing delivered.
//  Abort: rts=0 at any smp while in DATA or STOP -> IDLE. No delivery, no flag.
//  sz is held for the whole frame; a size8 change mid-frame affects the next frame only.
//  bit_cnt is 3 bits; comparison is against N-1 (6 or 7), so no wrap.
//  Delivery latency: rx_valid and rx_data update on the clk edge that ends the STOP smp cycle.
//  Handshake: rx_valid stays high until the clk edge on which rx_ack=1, then clears.
//   rx_data is stable while rx_valid=1.
//  Delivery while rx_valid=1 and rx_ack=0: new character discarded, overrun<=1.
//  Delivery and rx_ack in the same cycle: new character loaded, rx_valid stays 1, no overrun.
//  overrun clears on rst_n only, or on the clk edge where rx_ack=1 and no overrun event
//   occurs in that cycle.
//  rx_ack while rx_valid=0 is ignored.
//  Back-to-back frames: a start bit on the smp right after STOP is accepted.
// STRUCTURE
//  Shared package/header: state encodings (IDLE/DATA/STOP), frame constants
//   (START_BIT=0, STOP_BIT=1, N7=7, N8=8).
//  Sub-module usrt_rx_sync: SYNC_STAGES synchroniser plus falling-edge detect, producing
//   smp and synchronised rts/rxd. Kept separate from the transmitter's posedge detector.
//  Top of block: FSM, shift register, bit counter, output/handshake registers.
// TESTING
//  1 8-bit 0xA5, rts high, rx_ack tied 1 -> rx_valid pulses 1 clk, rx_data=8'hA5,
//    frame_err=0, overrun=0.
//  2 7-bit 0x55 then 8-bit 0xFF back-to-back, size8 toggled during the first frame ->
//    rx_data=8'h55 then 8'hFF.
//  3 8-bit 0x3C with stop bit forced 0 -> frame_err one-clk pulse, rx_valid stays 0,
//    FSM back in IDLE.
//  4 Two frames 0x11, 0x22 with rx_ack held 0 -> rx_data=8'h11, overrun=1; then
//    rx_ack=1 for 1 clk -> rx_valid=0, overrun=0.
//  5 rts dropped after 4 data bits, then full frame 0x81 -> only 0x81 is delivered,
//    no flags raised.
//  6 rst_n pulsed low mid-DATA -> all outputs at reset values immediately (asynchronous);
//    the next full frame 0x7E is received correctly.

Source files
------------

// File: rtl/usrt_receiver_pkg.sv
// Shared definitions for the USRT receive path: FSM encoding and frame constants.
// Also holds small helpers that turn the latched character size into limits.
package usrt_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   N7        = 7;
  localparam int   N8        = 8;

  // Index of the final data bit for the latched size (6 or 7); bit_cnt never wraps.
  function automatic logic [2:0] last_bit_idx(input logic sz);
    return sz ? 3'(N8 - 1) : 3'(N7 - 1);
  endfunction

  function automatic logic [7:0] char_mask(input logic sz);
    return sz ? 8'hFF : 8'h7F;
  endfunction

endpackage

// File: rtl/usrt_receiver_if.sv
// Character-side handshake of the USRT receiver: data/valid/ack plus status flags.
// The receiver drives through the master modport, the consumer through slave.
interface usrt_receiver_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output busy,
    input  rx_ack
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  busy,
    output rx_ack
  );

endinterface

// File: rtl/usrt_rx_sync.sv
// Brings usrt_clk, rts_in and rxd into the clk domain and produces the mid-bit
// sample strobe smp from a falling edge of the synchronised usrt_clk.
module usrt_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic usrt_clk,
  input  logic rts_in,
  input  logic rxd,
  output logic smp,
  output logic rts_sync,
  output logic rxd_sync
);

  logic [2:0]                  raw;
  logic [SYNC_STAGES-1:0][2:0] chain;
  logic [2:0]                  synced;
  logic                        uclk_prev;

  assign raw    = {usrt_clk, rts_in, rxd};
  assign synced = chain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], raw};
    end
  end

  // rts/rxd are re-registered alongside smp so all three line up in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uclk_prev <= 1'b0;
      smp       <= 1'b0;
      rts_sync  <= 1'b0;
      rxd_sync  <= 1'b0;
    end else begin
      uclk_prev <= synced[2];
      smp       <= uclk_prev & ~synced[2];
      rts_sync  <= synced[1];
      rxd_sync  <= synced[0];
    end
  end

endmodule

// File: rtl/usrt_receiver.sv
// USRT receiver: frames 7/8-bit characters from the synchronised serial line and
// hands them out on a valid/ack interface with framing and overrun reporting.
module usrt_receiver
  import usrt_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            usrt_clk,
  input  logic            rts_in,
  input  logic            rxd,
  input  logic            size8,
  usrt_receiver_if.master rx
);

  logic       smp;
  logic       rts_s;
  logic       rxd_s;

  rx_state_t  state;
  logic       sz;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       busy_reg;

  logic [7:0] data_reg;
  logic       valid_reg;
  logic       frame_err_reg;
  logic       overrun_reg;

  logic       stop_smp;
  logic       deliver;
  logic       stop_bad;
  logic       consume;

  usrt_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .usrt_clk (usrt_clk),
    .rts_in   (rts_in),
    .rxd      (rxd),
    .smp      (smp),
    .rts_sync (rts_s),
    .rxd_sync (rxd_s)
  );

  // A dropped rts during STOP aborts, so neither delivery nor framing error fires.
  assign stop_smp = smp && (state == STOP) && rts_s;
  assign deliver  = stop_smp && (rxd_s == STOP_BIT);
  assign stop_bad = stop_smp && (rxd_s != STOP_BIT);
  assign consume  = valid_reg && rx.rx_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sz       <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      busy_reg <= 1'b0;
    end else if (smp) begin
      case (state)
        IDLE: begin
          if (rts_s && (rxd_s == START_BIT)) begin
            state    <= DATA;
            sz       <= size8;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            busy_reg <= 1'b1;
          end
        end
        DATA: begin
          if (!rts_s) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end else begin
            shift[bit_cnt] <= rxd_s;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == last_bit_idx(sz)) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  // A character arriving while the previous one is still unconsumed is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;

      if (deliver && valid_reg && !rx.rx_ack) begin
        overrun_reg <= 1'b1;
      end else if (consume) begin
        overrun_reg <= 1'b0;
      end

      if (deliver && (!valid_reg || rx.rx_ack)) begin
        data_reg  <= shift & char_mask(sz);
        valid_reg <= 1'b1;
      end else if (consume) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx.rx_data   = data_reg;
  assign rx.rx_valid  = valid_reg;
  assign rx.frame_err = frame_err_reg;
  assign rx.overrun   = overrun_reg;
  assign rx.busy      = busy_reg;

endmodule

// File: tb/tb_usrt_receiver.sv
// Directed bench for usrt_receiver: a vector table of single frames plus
// hand-written sequences for back-to-back, overrun, abort and reset cases.
module tb_usrt_receiver;

  logic clk;
  logic rst_n;
  logic usrt_clk;
  logic rts_in;
  logic rxd;
  logic size8;

  usrt_receiver_if rif ();

  usrt_receiver #(
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .usrt_clk (usrt_clk),
    .rts_in   (rts_in),
    .rxd      (rxd),
    .size8    (size8),
    .rx       (rif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rxq[$];
  int         ferr_cnt   = 0;
  bit         ferr_wide  = 0;
  bit         valid_wide = 0;
  bit         prev_ferr  = 0;
  bit         prev_take  = 0;

  // Records every consumed character and flags over-long pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rif.rx_valid && rif.rx_ack) rxq.push_back(rif.rx_data);
      if (rif.frame_err) ferr_cnt++;
      if (rif.frame_err && prev_ferr) ferr_wide = 1;
      if (rif.rx_valid && rif.rx_ack && prev_take) valid_wide = 1;
      prev_ferr = rif.frame_err;
      prev_take = rif.rx_valid && rif.rx_ack;
    end else begin
      prev_ferr = 0;
      prev_take = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ubit(input logic r, input logic v);
    rts_in   = r;
    rxd      = v;
    usrt_clk = 1'b1;
    #80;
    usrt_clk = 1'b0;
    #80;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit s8, input bit stop,
                            input int drop_after, input bit keep_rts, input bit flip);
    int n;
    n = s8 ? 8 : 7;
    @(negedge clk);
    size8 = s8;
    ubit(1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (drop_after >= 0 && i == drop_after) begin
        ubit(1'b0, 1'b1);
        $display("frame %02h aborted after %0d bits", d, i);
        return;
      end
      ubit(1'b1, d[i]);
      if (flip && i == 0) size8 = ~s8;
    end
    ubit(1'b1, stop);
    if (!keep_rts) ubit(1'b0, 1'b1);
    $display("frame %02h size8=%0d stop=%0d sent", d, s8, stop);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         s8;
    bit         stop;
    logic [7:0] exp_data;
    int         exp_n;
    int         exp_ferr;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];

  initial begin
    vec[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1, 0};
    vec[1] = '{8'h55, 1'b0, 1'b1, 8'h55, 1, 0};
    vec[2] = '{8'hFF, 1'b0, 1'b1, 8'h7F, 1, 0};
    vec[3] = '{8'h3C, 1'b1, 1'b0, 8'h00, 0, 1};
    vec[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1, 0};
    vec[5] = '{8'hC3, 1'b0, 1'b1, 8'h43, 1, 0};

    rst_n      = 1'b0;
    usrt_clk   = 1'b0;
    rts_in     = 1'b0;
    rxd        = 1'b1;
    size8      = 1'b1;
    rif.rx_ack = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset rx_data", rif.rx_data, 8'h00);
    chk("reset rx_valid", rif.rx_valid, 0);
    chk("reset frame_err", rif.frame_err, 0);
    chk("reset overrun", rif.overrun, 0);
    chk("reset busy", rif.busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    rif.rx_ack = 1'b1;
    for (int i = 0; i < NV; i++) begin
      rxq.delete();
      ferr_cnt = 0;
      send_frame(vec[i].data, vec[i].s8, vec[i].stop, -1, 0, 0);
      repeat (10) @(negedge clk);
      chk($sformatf("v%0d deliveries", i), rxq.size(), vec[i].exp_n);
      if (rxq.size() > 0) chk($sformatf("v%0d rx_data", i), rxq[0], vec[i].exp_data);
      chk($sformatf("v%0d frame_err pulses", i), ferr_cnt, vec[i].exp_ferr);
      chk($sformatf("v%0d busy idle", i), rif.busy, 0);
      chk($sformatf("v%0d overrun", i), rif.overrun, 0);
      chk($sformatf("v%0d rx_valid", i), rif.rx_valid, 0);
    end
    chk("frame_err one clk", ferr_wide, 0);
    chk("rx_valid one clk", valid_wide, 0);

    // Back-to-back: 7-bit 0x55 with size8 flipped mid-frame, then 8-bit 0xFF.
    rxq.delete();
    send_frame(8'h55, 1'b0, 1'b1, -1, 1, 1);
    send_frame(8'hFF, 1'b1, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    chk("b2b count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      chk("b2b first", rxq[0], 8'h55);
      chk("b2b second", rxq[1], 8'hFF);
    end

    // Overrun with rx_ack held low.
    rif.rx_ack = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    chk("ovr first valid", rif.rx_valid, 1);
    chk("ovr first data", rif.rx_data, 8'h11);
    chk("ovr first overrun", rif.overrun, 0);
    send_frame(8'h22, 1'b1, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    chk("ovr second valid", rif.rx_valid, 1);
    chk("ovr second data", rif.rx_data, 8'h11);
    chk("ovr second overrun", rif.overrun, 1);
    rif.rx_ack = 1'b1;
    @(negedge clk);
    rif.rx_ack = 1'b0;
    chk("ovr ack valid", rif.rx_valid, 0);
    chk("ovr ack overrun", rif.overrun, 0);
    $display("overrun sequence 11/22 acknowledged");

    // Abort by dropping rts, then a clean frame.
    rif.rx_ack = 1'b1;
    rxq.delete();
    ferr_cnt = 0;
    send_frame(8'hF0, 1'b1, 1'b1, 4, 0, 0);
    repeat (8) @(negedge clk);
    chk("abort busy", rif.busy, 0);
    send_frame(8'h81, 1'b1, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    chk("abort count", rxq.size(), 1);
    if (rxq.size() > 0) chk("abort data", rxq[0], 8'h81);
    chk("abort frame_err", ferr_cnt, 0);
    chk("abort overrun", rif.overrun, 0);

    // Asynchronous reset in the middle of DATA with a character pending.
    rif.rx_ack = 1'b0;
    send_frame(8'h99, 1'b1, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    chk("pre-reset valid", rif.rx_valid, 1);
    @(negedge clk);
    size8 = 1'b1;
    ubit(1'b1, 1'b0);
    ubit(1'b1, 1'b1);
    ubit(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("mid-data busy", rif.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst rx_valid", rif.rx_valid, 0);
    chk("async rst rx_data", rif.rx_data, 8'h00);
    chk("async rst busy", rif.busy, 0);
    chk("async rst overrun", rif.overrun, 0);
    rts_in = 1'b0;
    rxd    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("reset pulsed mid-frame");
    repeat (4) @(negedge clk);
    rif.rx_ack = 1'b1;
    rxq.delete();
    send_frame(8'h7E, 1'b1, 1'b1, -1, 0, 0);
    repeat (10) @(negedge clk);
    chk("post-reset count", rxq.size(), 1);
    if (rxq.size() > 0) chk("post-reset data", rxq[0], 8'h7E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
